alu_share_ctrl: RTL and testbench

Controller that shares one 64-bit Y86-64 ALU (addq/subq/andq/xorq) between two requesters, the execute stage (port 0) and an auxiliary address/compare unit (port 1). Round-robin arbitration, operand latching, a single registered ALU evaluation, and a held response with id. Port 0 operations may update the condition-code register (ZF, SF, OF) consumed by jXX/cmovXX logic.

---
 rtl/alu_share_ctrl_pkg.sv | 27 ++
 rtl/alu_share_ctrl_if.sv | 51 +++++
 rtl/alu_share_ctrl_alu_core_64.sv | 47 ++++
 rtl/alu_share_ctrl.sv | 140 ++++++++++++++
 tb/tb_alu_share_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// alu_share_ctrl_pkg
// Shared definitions for the shared Y86-64 ALU controller: ALU function
// encodings (Y86 ifun), condition-code bit positions and the controller
// FSM state type.
// Ports: none (package).

package alu_share_ctrl_pkg;

  localparam int ALU_W = 64;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  // Bit positions inside cc = {ZF, SF, OF}
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if
// Bundle of the two requester ports, the response port and the condition
// codes of the shared ALU controller.
// Modports:
//   master - requester/consumer side: drives reqN_valid/fun/a/b, req0_setcc,
//            rsp_ready; observes reqN_ready, rsp_*, cc.
//   slave  - controller side (alu_share_ctrl).

interface alu_share_ctrl_if #(
  parameter int WIDTH = 64
);
  import alu_share_ctrl_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_fun;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_setcc;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_fun;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  logic [2:0]       cc;

  modport master (
    output req0_valid, req0_fun, req0_a, req0_b, req0_setcc,
    output req1_valid, req1_fun, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err, cc
  );

  modport slave (
    input  req0_valid, req0_fun, req0_a, req0_b, req0_setcc,
    input  req1_valid, req1_fun, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err, cc
  );

endinterface

// File: rtl/alu_share_ctrl_alu_core_64.sv
// alu_core_64
// Purely combinational Y86-64 ALU (addq/subq/andq/xorq).
// Ports:
//   fun  in  4   Y86 ifun (0 add, 1 sub, 2 and, 3 xor; others illegal)
//   a    in  64  valA
//   b    in  64  valB
//   r    out 64  result (b op a); 0 for illegal fun
//   zf/sf/of out flags of r
//   err  out     illegal fun

module alu_core_64
  import alu_share_ctrl_pkg::*;
(
  input  logic [3:0]  fun,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] r,
  output logic        zf,
  output logic        sf,
  output logic        of,
  output logic        err
);

  always_comb begin
    r   = '0;
    of  = 1'b0;
    err = 1'b0;
    case (fun)
      ALU_ADD: begin
        r  = b + a;
        of = (a[63] == b[63]) && (r[63] != b[63]);
      end
      // Y86 subq rA,rB computes rB - rA, so b is the minuend
      ALU_SUB: begin
        r  = b - a;
        of = (a[63] != b[63]) && (r[63] != b[63]);
      end
      ALU_AND: r = b & a;
      ALU_XOR: r = b ^ a;
      default: err = 1'b1;
    endcase
  end

  assign zf = (r == '0);
  assign sf = r[63];

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
// Shares one 64-bit Y86-64 ALU between the execute stage (port 0) and an
// auxiliary address/compare unit (port 1). Round-robin arbitration in IDLE,
// operands latched on handshake, one registered ALU evaluation, response held
// until taken.
// Build option: ALU_SHARE_CC_EN - when defined, port-0 ops with setcc update
// the {ZF,SF,OF} register; when undefined, cc is tied to 0 and req0_setcc is
// ignored.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    alu_share_ctrl_if.slave (requests, response, cc)
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | arbitrate; ready to the granted requester; latch on handshake
// ST_EXEC | evaluate ALU on latched operands; register result/err/cc
// ST_RESP | hold rsp_valid and result until rsp_ready

module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  alu_share_ctrl_if.slave bus
);

  state_t      state_q, state_d;
  logic        ptr_q;
  logic        id_q;
  logic [3:0]  fun_q;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic [63:0] data_q;
  logic        err_q;

  logic        grant_any;
  logic        grant_id;
  logic        accept;

  logic [63:0] alu_r;
  logic        alu_zf, alu_sf, alu_of, alu_err;

  // Tie goes to the port that did not win last time; ptr_q holds last grant.
  assign grant_any = bus.req0_valid | bus.req1_valid;
  assign grant_id  = (bus.req0_valid & bus.req1_valid) ? ~ptr_q : bus.req1_valid;

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // rst_n gating keeps ready low while reset is asserted
        if (grant_any && rst_n) begin
          accept         = 1'b1;
          bus.req0_ready = ~grant_id;
          bus.req1_ready = grant_id;
          state_d        = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b1;
      id_q    <= 1'b0;
      fun_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q <= grant_id;
        id_q  <= grant_id;
        fun_q <= grant_id ? bus.req1_fun : bus.req0_fun;
        a_q   <= grant_id ? bus.req1_a   : bus.req0_a;
        b_q   <= grant_id ? bus.req1_b   : bus.req0_b;
      end
      if (state_q == ST_EXEC) begin
        data_q <= alu_r;
        err_q  <= alu_err;
      end
    end
  end

  alu_core_64 u_alu (
    .fun (fun_q),
    .a   (a_q),
    .b   (b_q),
    .r   (alu_r),
    .zf  (alu_zf),
    .sf  (alu_sf),
    .of  (alu_of),
    .err (alu_err)
  );

  assign bus.rsp_id   = id_q;
  assign bus.rsp_data = data_q;
  assign bus.rsp_err  = err_q;

`ifdef ALU_SHARE_CC_EN
  logic       setcc_q;
  logic [2:0] cc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      setcc_q <= 1'b0;
      cc_q    <= 3'b000;
    end else begin
      if (accept) setcc_q <= ~grant_id & bus.req0_setcc;
      // setcc_q already implies port 0; illegal fun leaves cc untouched
      if ((state_q == ST_EXEC) && setcc_q && !alu_err) begin
        cc_q[CC_ZF] <= alu_zf;
        cc_q[CC_SF] <= alu_sf;
        cc_q[CC_OF] <= alu_of;
      end
    end
  end

  assign bus.cc = cc_q;
`else
  logic unused_cc_inputs;
  assign unused_cc_inputs = ^{alu_zf, alu_sf, alu_of, bus.req0_setcc};
  assign bus.cc = 3'b000;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl
// Directed bench for alu_share_ctrl with a transaction-level reference model
// checked every cycle, plus literal expectations on each taken response.

module tb_alu_share_ctrl;

`ifdef ALU_SHARE_CC_EN
  localparam bit CC_ON = 1'b1;
`else
  localparam bit CC_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_share_ctrl_if #(.WIDTH(64)) bus ();

  alu_share_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU from arithmetic definitions: overflow via 65-bit
  // sign-extended result disagreeing in its top two bits.
  function automatic void ref_alu(input logic [3:0] f, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] r,
                                  output logic e, output logic [2:0] fl);
    logic [64:0] s;
    logic        ov;
    s  = '0;
    ov = 1'b0;
    e  = 1'b0;
    r  = '0;
    if (f == 4'd0) begin
      s = {b[63], b} + {a[63], a};
      r = s[63:0]; ov = s[64] ^ s[63];
    end else if (f == 4'd1) begin
      s = {b[63], b} - {a[63], a};
      r = s[63:0]; ov = s[64] ^ s[63];
    end else if (f == 4'd2) r = a & b;
    else if (f == 4'd3) r = a ^ b;
    else e = 1'b1;
    fl = {r == 64'd0, r[63], ov};
  endfunction

  // Transaction model: one op in flight, responses visible two cycles after
  // acceptance, last-granted port remembered for tie-breaking.
  bit          m_busy;
  int          m_age;
  bit          m_last;
  bit          m_id;
  logic [63:0] m_r;
  logic        m_err;
  logic [2:0]  m_cc;
  logic [2:0]  m_cc_pend;
  bit          m_cc_upd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_age = 0; m_last = 1; m_id = 0;
      m_r = '0; m_err = 0; m_cc = 3'b000; m_cc_upd = 0; m_cc_pend = 3'b000;
    end else if (!m_busy) begin
      if (bus.req0_valid || bus.req1_valid) begin
        bit g;
        g = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
        m_busy = 1; m_age = 1; m_last = g; m_id = g;
        if (g) ref_alu(bus.req1_fun, bus.req1_a, bus.req1_b, m_r, m_err, m_cc_pend);
        else   ref_alu(bus.req0_fun, bus.req0_a, bus.req0_b, m_r, m_err, m_cc_pend);
        m_cc_upd = CC_ON && !g && bus.req0_setcc && !m_err;
      end
    end else if (m_age == 1) begin
      m_age = 2;
      if (m_cc_upd) m_cc = m_cc_pend;
    end else if (bus.rsp_ready) begin
      m_busy = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ready0", bus.req0_ready, 0);
      check("rst_ready1", bus.req1_ready, 0);
      check("rst_valid", bus.rsp_valid, 0);
      check("rst_id", bus.rsp_id, 0);
      check("rst_data", bus.rsp_data, 0);
      check("rst_err", bus.rsp_err, 0);
      check("rst_cc", bus.cc, 0);
    end else begin
      bit g, any;
      any = bus.req0_valid || bus.req1_valid;
      g   = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
      check("cyc_ready0", bus.req0_ready, !m_busy && any && !g);
      check("cyc_ready1", bus.req1_ready, !m_busy && any && g);
      check("cyc_valid", bus.rsp_valid, m_busy && m_age >= 2);
      check("cyc_cc", bus.cc, m_cc);
      if (m_busy && m_age >= 2) begin
        check("cyc_id", bus.rsp_id, m_id);
        check("cyc_data", bus.rsp_data, m_r);
        check("cyc_err", bus.rsp_err, m_err);
      end
    end
  end

  task automatic wait_accept(input bit p);
    bit got;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (p ? bus.req1_ready : bus.req0_ready) begin
        got = 1;
        break;
      end
    end
    check("accept_seen", got, 1);
    @(posedge clk);
    #1;
    if (p) bus.req1_valid = 1'b0;
    else   bus.req0_valid = 1'b0;
  endtask

  task automatic issue(input bit p, input logic [3:0] f, input logic [63:0] a,
                       input logic [63:0] b, input bit sc);
    if (p) begin
      bus.req1_fun = f; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_fun = f; bus.req0_a = a; bus.req0_b = b; bus.req0_setcc = sc;
      bus.req0_valid = 1'b1;
    end
    wait_accept(p);
  endtask

  task automatic wait_rsp(input string nm, input bit id, input logic [63:0] data,
                          input bit err, input logic [2:0] cc);
    bit got;
    got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) begin
        got = 1;
        break;
      end
    end
    check({nm, "_seen"}, got, 1);
    if (got) begin
      check({nm, "_id"}, bus.rsp_id, id);
      check({nm, "_data"}, bus.rsp_data, data);
      check({nm, "_err"}, bus.rsp_err, err);
      check({nm, "_cc"}, bus.cc, cc & {3{CC_ON}});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.req0_valid = 0; bus.req0_fun = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req0_setcc = 0;
    bus.req1_valid = 0; bus.req1_fun = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp_ready  = 1'b1;
    rst_n = 1'b1;
    #1;
    do_reset();

    // basic sub and negative result, then port 1 leaves cc alone
    issue(0, 4'd1, 64'd20, 64'd50, 1);
    wait_rsp("sub_pos", 0, 64'd30, 0, 3'b000);
    issue(0, 4'd1, 64'd50, 64'd20, 1);
    wait_rsp("sub_neg", 0, 64'hFFFF_FFFF_FFFF_FFE2, 0, 3'b010);
    issue(1, 4'd0, 64'd5, 64'd5, 0);
    wait_rsp("p1_add", 1, 64'd10, 0, 3'b010);

    // signed overflow, then zero
    issue(0, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1);
    wait_rsp("add_ovf", 0, 64'h8000_0000_0000_0000, 0, 3'b011);
    issue(0, 4'd1, 64'd1, 64'd1, 1);
    wait_rsp("sub_zero", 0, 64'd0, 0, 3'b100);

    // round robin with both requesters held valid from reset
    do_reset();
    bus.req0_fun = 4'd3; bus.req0_a = 64'd5; bus.req0_b = 64'd5; bus.req0_setcc = 1;
    bus.req1_fun = 4'd2; bus.req1_a = 64'hF0; bus.req1_b = 64'hFF;
    bus.req0_valid = 1; bus.req1_valid = 1;
    wait_rsp("rr0", 0, 64'd0, 0, 3'b100);
    wait_rsp("rr1", 1, 64'hF0, 0, 3'b100);
    wait_rsp("rr2", 0, 64'd0, 0, 3'b100);
    wait_rsp("rr3", 1, 64'hF0, 0, 3'b100);
    bus.req0_valid = 0; bus.req1_valid = 0;

    // consumer stall with a pending port-1 request
    bus.rsp_ready = 1'b0;
    issue(0, 4'd2, 64'h0F, 64'hFF, 0);
    bus.req1_fun = 4'd0; bus.req1_a = 64'd2; bus.req1_b = 64'd3; bus.req1_valid = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", bus.rsp_valid, 1);
      check("stall_ready0", bus.req0_ready, 0);
      check("stall_ready1", bus.req1_ready, 0);
      check("stall_data", bus.rsp_data, 64'h0F);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    wait_rsp("stall_and", 0, 64'h0F, 0, 3'b100);
    wait_accept(1);
    wait_rsp("after_stall", 1, 64'd5, 0, 3'b100);

    // illegal function
    issue(0, 4'd7, 64'd1, 64'd1, 1);
    wait_rsp("illegal", 0, 64'd0, 1, 3'b100);

    // reset while an op is executing
    issue(0, 4'd0, 64'd3, 64'd4, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstx_valid", bus.rsp_valid, 0);
    check("rstx_err", bus.rsp_err, 0);
    check("rstx_cc", bus.cc, 0);
    check("rstx_data", bus.rsp_data, 0);
    check("rstx_id", bus.rsp_id, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstx_no_rsp", bus.rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    issue(0, 4'd1, 64'd7, 64'd9, 1);
    wait_rsp("post_rst", 0, 64'd2, 0, 3'b000);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
